minesweeper_renderer: RTL and testbench
=======================================

MINESWEEPER_RENDERER -- requirements
Module: minesweeper_renderer

Interface
REQ-001 clk  input  1  system clock; all state on posedge clk.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 pix_en  input  1  one-cycle strobe, once per pixel (clk/4); the pipeline advances only on strobes.
REQ-004 hCount, vCount  input  10 each  raster position from the display controller; valid on pix_en.
REQ-005 bright, hSync, vSync  input  1 each  active-video flag and raw syncs from the display controller.
REQ-006 tile_addr  output  8  board RAM read address {row[3:0], col[3:0]}, registered.
REQ-007 tile_data  input  4  board RAM read data, valid one clk after tile_addr changes.
REQ-008 cur_x, cur_y  input  4 each  cursor cell.
REQ-009 game_state  input  2  0 playing, 1 won, 2 lost, 3 treated as playing.
REQ-010 rgb  output  8  {R[2:0], G[2:0], B[1:0]}, registered.
REQ-011 hSync_out, vSync_out  output  1 each  syncs delayed to align with rgb.

Function
REQ-012 Board window: hCount 224..703, vCount 36..515; 16x16 cells of 30x30 pixels.
REQ-013 Stage 1, on pix_en: register col/px, row/py, in_board, bright, hSync and vSync; drive tile_addr.
REQ-014 col/px update: sampled hCount==224 -> col=0, px=0; otherwise px==29 -> px=0 and col+1; otherwise px+1. col wraps from 15 to 0.
REQ-015 row/py update only on strobes with sampled hCount==0: vCount==36 -> row=0, py=0; vCount 37..515 -> advance as in REQ-014; otherwise hold.
REQ-016 Stage 2, on the next pix_en: compute rgb from the stage-1 registers and tile_data; shift the syncs. Total latency is exactly 2 pix_en strobes from input to rgb/hSync_out/vSync_out.
REQ-017 Colour priority (highest first):
- bright==0 -> rgb 8'h00.
- Outside the board -> background: 8'h49 (playing), 8'h1C (won), 8'hA0 (lost).
- px==0 or py==0 -> grid line 8'h24.
- Cursor cell (col==cur_x, row==cur_y) and px<2, px>27, py<2 or py>27 -> 8'hFC.
- Otherwise tile_data per REQ-018.
REQ-018 tile_data encoding:
- 0 -> revealed blank 8'hB6.
- 1..8 -> 7-segment glyph on 8'hB6; segments span px 10..19, py 6..23, 2 pixels thick, in digit colour (1 8'h03, 2 8'h10, 3 8'hE0, others 8'h80).
- 9 -> mine: square px 10..19, py 10..19 in 8'h00 on 8'hE0.
- 10 and 12..15 -> hidden 8'h92.
- 11 -> flag: px 10..19, py 6..13 in 8'hE0; pole px 14..15, py 14..23 in 8'h00; on 8'h92.
REQ-019 No strobe -> all registers hold, tile_addr stable.

Reset
REQ-020 While rst is high:
- rgb=0, tile_addr=0.
- col, row, px, py = 0; in_board=0; stage brights = 0.
- Sync pipeline, hSync_out, vSync_out = 1.
- Blink counter = 0.
REQ-021 rst deasserted mid-frame -> valid output from the next frame start (vCount==36, hCount==0/224). Output before that is don't-care, but bright==0 must still give rgb 0.

Configuration
REQ-022 RENDER_CURSOR_BLINK_EN defined:
- 5-bit frame counter increments on the strobe with sampled hCount==0 and vCount==0.
- Cursor border is drawn only while counter bit 4 == 0 (toggles every 16 frames).
REQ-023 RENDER_CURSOR_BLINK_EN undefined: no counter; cursor border always drawn.

Verification
REQ-024 Reset mid-frame, release -> rgb 8'h00, syncs 1; first board pixel matches REQ-017 after the next frame start.
REQ-025 Strobe hCount=224, vCount=36, bright=1 with tile_data=10 -> exactly 2 strobes later rgb=8'h24, tile_addr=8'h00.
REQ-026 Pixel hCount=269, vCount=81 (col 1, px 15; row 1, py 15), tile_data=9 -> tile_addr=8'h11, rgb=8'h00; at px 5 -> 8'hE0.
REQ-027 cur_x=3, cur_y=2, pixel px=1 of cell (3,2) -> 8'hFC; same pixel of cell (4,2) -> tile colour.
REQ-028 game_state=2, hCount=150, bright=1 -> 8'hA0; hSync pulse in -> hSync_out pulse delayed exactly 2 strobes.
REQ-029 With RENDER_CURSOR_BLINK_EN: cursor border present in frames 0-15, absent in 16-31. Without it: present in all frames.

Source files
------------

// File: rtl/minesweeper_renderer.sv
// Minesweeper board renderer: raster position + board RAM tile -> 8-bit RGB pixel.
// Latency: 2 pix_en strobes from hCount/vCount/syncs to rgb/hSync_out/vSync_out.
// Backpressure: none; advances only on pix_en. Option macro: RENDER_CURSOR_BLINK_EN.
module minesweeper_renderer (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    input  logic [9:0] hCount,
    input  logic [9:0] vCount,
    input  logic       bright,
    input  logic       hSync,
    input  logic       vSync,
    output logic [7:0] tile_addr,
    input  logic [3:0] tile_data,
    input  logic [3:0] cur_x,
    input  logic [3:0] cur_y,
    input  logic [1:0] game_state,
    output logic [7:0] rgb,
    output logic       hSync_out,
    output logic       vSync_out
);

    // Stage-1 registers: cell coordinates and pixel offset inside the cell.
    logic [3:0] col, row;
    logic [4:0] px, py;
    logic       in_board;
    logic       bright_s1;
    logic       hsync_s1, vsync_s1;

    logic [3:0] col_nxt, row_nxt;
    logic [4:0] px_nxt, py_nxt;
    logic       show_cursor;
    logic [7:0] colour;

    // Next cell position: column steps every pixel, row steps once per line at hCount==0.
    always_comb begin
        col_nxt = col;
        px_nxt  = px;
        row_nxt = row;
        py_nxt  = py;
        if (hCount == 10'd224) begin
            col_nxt = 4'd0;
            px_nxt  = 5'd0;
        end else if (px == 5'd29) begin
            col_nxt = col + 4'd1;
            px_nxt  = 5'd0;
        end else begin
            px_nxt  = px + 5'd1;
        end
        if (hCount == 10'd0) begin
            if (vCount == 10'd36) begin
                row_nxt = 4'd0;
                py_nxt  = 5'd0;
            end else if (vCount >= 10'd37 && vCount <= 10'd515) begin
                if (py == 5'd29) begin
                    row_nxt = row + 4'd1;
                    py_nxt  = 5'd0;
                end else begin
                    py_nxt  = py + 5'd1;
                end
            end
        end
    end

    // Stage 1: capture position, board window flag and syncs; issue the board RAM read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= 4'd0;
            row       <= 4'd0;
            px        <= 5'd0;
            py        <= 5'd0;
            in_board  <= 1'b0;
            bright_s1 <= 1'b0;
            hsync_s1  <= 1'b1;
            vsync_s1  <= 1'b1;
            tile_addr <= 8'h00;
        end else if (pix_en) begin
            col       <= col_nxt;
            row       <= row_nxt;
            px        <= px_nxt;
            py        <= py_nxt;
            in_board  <= (hCount >= 10'd224) && (hCount <= 10'd703) &&
                         (vCount >= 10'd36)  && (vCount <= 10'd515);
            bright_s1 <= bright;
            hsync_s1  <= hSync;
            vsync_s1  <= vSync;
            tile_addr <= {row_nxt, col_nxt};
        end
    end

`ifdef RENDER_CURSOR_BLINK_EN
    logic [4:0] frame_cnt;

    // Frame counter ticks at the top-left of each frame; bit 4 gates the cursor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= 5'd0;
        end else if (pix_en && hCount == 10'd0 && vCount == 10'd0) begin
            frame_cnt <= frame_cnt + 5'd1;
        end
    end

    assign show_cursor = ~frame_cnt[4];
`else
    assign show_cursor = 1'b1;
`endif

    // Glyph geometry inside a cell; segment vector ordered {a,b,c,d,e,f,g}.
    logic       x_span, x_left, x_right, y_top, y_mid, y_bot, y_upper, y_lower;
    logic [6:0] seg_hit, seg_mask;
    logic [7:0] digit_colour;
    logic       border, cursor_cell;

    assign x_span  = (px >= 5'd10) && (px <= 5'd19);
    assign x_left  = (px >= 5'd10) && (px <= 5'd11);
    assign x_right = (px >= 5'd18) && (px <= 5'd19);
    assign y_top   = (py >= 5'd6)  && (py <= 5'd7);
    assign y_mid   = (py >= 5'd14) && (py <= 5'd15);
    assign y_bot   = (py >= 5'd22) && (py <= 5'd23);
    assign y_upper = (py >= 5'd6)  && (py <= 5'd15);
    assign y_lower = (py >= 5'd14) && (py <= 5'd23);

    assign seg_hit = {x_span & y_top,     // a
                      x_right & y_upper,  // b
                      x_right & y_lower,  // c
                      x_span & y_bot,     // d
                      x_left & y_lower,   // e
                      x_left & y_upper,   // f
                      x_span & y_mid};    // g

    assign border      = (px < 5'd2) || (px > 5'd27) || (py < 5'd2) || (py > 5'd27);
    assign cursor_cell = (col == cur_x) && (row == cur_y);

    // Digit segment pattern and ink colour for values 1..8.
    always_comb begin
        seg_mask     = 7'b0000000;
        digit_colour = 8'h80;
        case (tile_data)
            4'd1: begin seg_mask = 7'b0110000; digit_colour = 8'h03; end
            4'd2: begin seg_mask = 7'b1101101; digit_colour = 8'h10; end
            4'd3: begin seg_mask = 7'b1111001; digit_colour = 8'hE0; end
            4'd4: seg_mask = 7'b0110011;
            4'd5: seg_mask = 7'b1011011;
            4'd6: seg_mask = 7'b1011111;
            4'd7: seg_mask = 7'b1110000;
            4'd8: seg_mask = 7'b1111111;
            default: seg_mask = 7'b0000000;
        endcase
    end

    // Pixel colour by priority: blanking, background, grid, cursor, tile content.
    always_comb begin
        colour = 8'h00;
        if (!bright_s1) begin
            colour = 8'h00;
        end else if (!in_board) begin
            case (game_state)
                2'd1:    colour = 8'h1C;
                2'd2:    colour = 8'hA0;
                default: colour = 8'h49;
            endcase
        end else if (px == 5'd0 || py == 5'd0) begin
            colour = 8'h24;
        end else if (cursor_cell && border && show_cursor) begin
            colour = 8'hFC;
        end else begin
            case (tile_data)
                4'd0: colour = 8'hB6;
                4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8:
                    colour = |(seg_hit & seg_mask) ? digit_colour : 8'hB6;
                4'd9: begin
                    if (x_span && py >= 5'd10 && py <= 5'd19) colour = 8'h00;
                    else                                     colour = 8'hE0;
                end
                4'd11: begin
                    if (x_span && py >= 5'd6 && py <= 5'd13)
                        colour = 8'hE0;
                    else if (px >= 5'd14 && px <= 5'd15 && py >= 5'd14 && py <= 5'd23)
                        colour = 8'h00;
                    else
                        colour = 8'h92;
                end
                default: colour = 8'h92;
            endcase
        end
    end

    // Stage 2: register the pixel colour and the matching syncs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb       <= 8'h00;
            hSync_out <= 1'b1;
            vSync_out <= 1'b1;
        end else if (pix_en) begin
            rgb       <= colour;
            hSync_out <= hsync_s1;
            vSync_out <= vsync_s1;
        end
    end

endmodule

// File: tb/tb_minesweeper_renderer.sv
// Directed bench for minesweeper_renderer with a registered board RAM model.
// Each task drives strobes and compares outputs at the falling clock edge.
// Build with RENDER_CURSOR_BLINK_EN to exercise the blinking cursor variant.
module tb_minesweeper_renderer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_en = 1'b0;
    logic [9:0] hCount = 10'd0;
    logic [9:0] vCount = 10'd0;
    logic       bright = 1'b0;
    logic       hSync = 1'b1;
    logic       vSync = 1'b1;
    logic [7:0] tile_addr;
    logic [3:0] tile_data = 4'd0;
    logic [3:0] cur_x = 4'd3;
    logic [3:0] cur_y = 4'd2;
    logic [1:0] game_state = 2'd0;
    logic [7:0] rgb;
    logic       hSync_out;
    logic       vSync_out;

    logic [3:0] board [0:255];
    int n_chk  = 0;
    int n_fail = 0;

    minesweeper_renderer dut (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .hCount(hCount), .vCount(vCount),
        .bright(bright), .hSync(hSync), .vSync(vSync),
        .tile_addr(tile_addr), .tile_data(tile_data),
        .cur_x(cur_x), .cur_y(cur_y), .game_state(game_state),
        .rgb(rgb), .hSync_out(hSync_out), .vSync_out(vSync_out)
    );

    always #5 clk = ~clk;

    // Board RAM: one-clock read latency.
    always @(posedge clk) tile_data <= board[tile_addr];

    // One pixel: strobe for one clock, then three idle clocks; returns at a falling edge.
    task automatic strobe(input logic [9:0] h, input logic [9:0] v,
                          input logic b, input logic hs, input logic vs);
        hCount = h; vCount = v; bright = b; hSync = hs; vSync = vs;
        pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Walk from frame start to (h,v): line starts down to v, then pixels across to h.
    task automatic goto_pix(input int h, input int v);
        for (int y = 36; y <= v; y++) strobe(10'(0), 10'(y), 1'b0, 1'b1, 1'b1);
        for (int x = 224; x <= h; x++) strobe(10'(x), 10'(v), 1'b1, 1'b1, 1'b1);
    endtask

    // One more strobe off the board so the last walked pixel reaches rgb.
    task automatic flush(input int v);
        strobe(10'd704, 10'(v), 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_chk++; if (rgb !== 8'h00) begin n_fail++; $display("FAIL reset_rgb got %h want 00", rgb); end
        n_chk++; if (tile_addr !== 8'h00) begin n_fail++; $display("FAIL reset_tile_addr got %h want 00", tile_addr); end
        n_chk++; if (hSync_out !== 1'b1 || vSync_out !== 1'b1) begin n_fail++; $display("FAIL reset_syncs got %b%b want 11", hSync_out, vSync_out); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) strobe(10'd300, 10'd200, 1'b1, 1'b0, 1'b0);
        n_chk++; if (hSync_out !== 1'b0) begin n_fail++; $display("FAIL run_hsync got %b want 0", hSync_out); end
        // Mid-frame asynchronous reset.
        #2 rst = 1'b1;
        #1;
        n_chk++; if (rgb !== 8'h00 || hSync_out !== 1'b1 || vSync_out !== 1'b1) begin
            n_fail++; $display("FAIL midreset_out got rgb %h syncs %b%b want 00 11", rgb, hSync_out, vSync_out); end
        @(negedge clk);
        rst = 1'b0;
        strobe(10'd400, 10'd300, 1'b0, 1'b1, 1'b1);
        strobe(10'd401, 10'd300, 1'b0, 1'b1, 1'b1);
        n_chk++; if (rgb !== 8'h00) begin n_fail++; $display("FAIL blank_after_reset got %h want 00", rgb); end
        // First board pixel after the next frame start: cell (0,0), px 5, py 5, hidden.
        goto_pix(229, 41);
        flush(41);
        n_chk++; if (rgb !== 8'h92) begin n_fail++; $display("FAIL first_frame_pixel got %h want 92", rgb); end
    endtask

    task automatic test_origin;
        goto_pix(224, 36);
        n_chk++; if (tile_addr !== 8'h00) begin n_fail++; $display("FAIL origin_addr got %h want 00", tile_addr); end
        // Only one strobe after sampling: rgb must still hold the previous pixel (blanked).
        n_chk++; if (rgb === 8'h24) begin n_fail++; $display("FAIL origin_early got %h want not 24", rgb); end
        flush(36);
        n_chk++; if (rgb !== 8'h24) begin n_fail++; $display("FAIL origin_grid got %h want 24", rgb); end
    endtask

    task automatic test_mine;
        goto_pix(269, 81);
        n_chk++; if (tile_addr !== 8'h11) begin n_fail++; $display("FAIL mine_addr got %h want 11", tile_addr); end
        flush(81);
        n_chk++; if (rgb !== 8'h00) begin n_fail++; $display("FAIL mine_centre got %h want 00", rgb); end
        goto_pix(259, 81);
        flush(81);
        n_chk++; if (rgb !== 8'hE0) begin n_fail++; $display("FAIL mine_edge got %h want E0", rgb); end
    endtask

    task automatic test_glyphs;
        goto_pix(302, 74); flush(74);   // digit 1, segment b
        n_chk++; if (rgb !== 8'h03) begin n_fail++; $display("FAIL digit1_seg got %h want 03", rgb); end
        goto_pix(296, 74); flush(74);   // digit 1, off-segment
        n_chk++; if (rgb !== 8'hB6) begin n_fail++; $display("FAIL digit1_bg got %h want B6", rgb); end
        goto_pix(329, 72); flush(72);   // digit 2, segment a
        n_chk++; if (rgb !== 8'h10) begin n_fail++; $display("FAIL digit2_seg got %h want 10", rgb); end
        goto_pix(359, 84); flush(84);   // flag pole
        n_chk++; if (rgb !== 8'h00) begin n_fail++; $display("FAIL flag_pole got %h want 00", rgb); end
        goto_pix(356, 74); flush(74);   // flag cloth
        n_chk++; if (rgb !== 8'hE0) begin n_fail++; $display("FAIL flag_cloth got %h want E0", rgb); end
        goto_pix(379, 71); flush(71);   // revealed blank
        n_chk++; if (rgb !== 8'hB6) begin n_fail++; $display("FAIL blank_tile got %h want B6", rgb); end
    endtask

    task automatic test_cursor;
        goto_pix(315, 101); flush(101);
        n_chk++; if (rgb !== 8'hFC) begin n_fail++; $display("FAIL cursor_left got %h want FC", rgb); end
        goto_pix(342, 101); flush(101);
        n_chk++; if (rgb !== 8'hFC) begin n_fail++; $display("FAIL cursor_right got %h want FC", rgb); end
        goto_pix(329, 111); flush(111);
        n_chk++; if (rgb !== 8'h92) begin n_fail++; $display("FAIL cursor_inner got %h want 92", rgb); end
        goto_pix(345, 101); flush(101);
        n_chk++; if (rgb !== 8'h92) begin n_fail++; $display("FAIL neighbour_cell got %h want 92", rgb); end
    endtask

    task automatic test_background_sync;
        logic hs_seq [0:5];
        logic vs_seq [0:5];
        logic [7:0] bg_want [0:3];
        hs_seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vs_seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        bg_want = '{8'h49, 8'h1C, 8'hA0, 8'h49};
        for (int g = 0; g < 4; g++) begin
            game_state = 2'(g);
            strobe(10'd150, 10'd100, 1'b1, 1'b1, 1'b1);
            strobe(10'd151, 10'd100, 1'b1, 1'b1, 1'b1);
            n_chk++; if (rgb !== bg_want[g]) begin n_fail++; $display("FAIL background_%0d got %h want %h", g, rgb, bg_want[g]); end
        end
        game_state = 2'd2;
        for (int n = 0; n < 6; n++) begin
            strobe(10'd150, 10'd100, 1'b1, hs_seq[n], vs_seq[n]);
            if (n >= 1) begin
                n_chk++; if (hSync_out !== hs_seq[n-1] || vSync_out !== vs_seq[n-1]) begin
                    n_fail++; $display("FAIL sync_delay_%0d got %b%b want %b%b", n, hSync_out, vSync_out, hs_seq[n-1], vs_seq[n-1]); end
            end
        end
        n_chk++; if (rgb !== 8'hA0) begin n_fail++; $display("FAIL lost_bg got %h want A0", rgb); end
        game_state = 2'd0;
        strobe(10'd150, 10'd100, 1'b0, 1'b1, 1'b1);
        strobe(10'd151, 10'd100, 1'b0, 1'b1, 1'b1);
        n_chk++; if (rgb !== 8'h00) begin n_fail++; $display("FAIL bright_off got %h want 00", rgb); end
    endtask

    task automatic test_blink;
        logic [7:0] want_off;
`ifdef RENDER_CURSOR_BLINK_EN
        want_off = 8'h92;
`else
        want_off = 8'hFC;
`endif
        for (int f = 0; f < 16; f++) strobe(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
        goto_pix(315, 101); flush(101);
        n_chk++; if (rgb !== want_off) begin n_fail++; $display("FAIL blink_frame16 got %h want %h", rgb, want_off); end
        for (int f = 0; f < 16; f++) strobe(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
        goto_pix(315, 101); flush(101);
        n_chk++; if (rgb !== 8'hFC) begin n_fail++; $display("FAIL blink_frame32 got %h want FC", rgb); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) board[i] = 4'd10;
        board[8'h11] = 4'd9;
        board[8'h12] = 4'd1;
        board[8'h13] = 4'd2;
        board[8'h14] = 4'd11;
        board[8'h15] = 4'd0;
        test_reset();
        test_origin();
        test_mine();
        test_glyphs();
        test_cursor();
        test_background_sync();
        test_blink();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
